countdown_timer: RTL and testbench

Three-digit BCD countdown timer driving three 7-segment digits through the team's FND decoder; the count-down counterpart of the stopwatch on the same board. The user edits a preset with two buttons, starts, pauses and cancels with two more, and the block raises an alarm when the count reaches 000. It sits directly between the debounced push-button inputs and the FND pins.

---
 rtl/countdown_timer.sv | 188 ++++++++++++++++++
 tb/tb_countdown_timer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Three-digit BCD countdown timer with button-edited preset, pause/cancel and 7-segment outputs.
// Define TIMER_RELOAD_EN to reload the preset on expiry (periodic alarm pulse) instead of stopping in DONE.
module countdown_timer #(
  parameter int unsigned LST_CLK = 100_000_000/10 - 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_fStart,
  input  logic       i_fStop,
  input  logic       i_fSel,
  input  logic       i_fInc,
  output logic [6:0] o_Sec0,
  output logic [6:0] o_Sec1,
  output logic [6:0] o_Sec2,
  output logic [1:0] o_Sel,
  output logic       o_Alarm
);

  localparam int PW = (LST_CLK > 0) ? $clog2(LST_CLK + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(LST_CLK);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [11:0]   preset_q, preset_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          alarm_q, alarm_d;
  logic [3:0]    btn_prev_q, btn_now, btn_ev;
  logic          start_ev, stop_ev, sel_ev, inc_ev, tick, term;
  logic [11:0]   disp;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] d0, d1, d2;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    if (d0 != 4'd0) begin
      d0 = d0 - 4'd1;
    end else begin
      d0 = 4'd9;
      if (d1 != 4'd0) begin
        d1 = d1 - 4'd1;
      end else begin
        d1 = 4'd9;
        d2 = (d2 != 4'd0) ? d2 - 4'd1 : 4'd0;
      end
    end
    return {d2, d1, d0};
  endfunction

  // Segment order gfedcba, active-high.
  function automatic logic [6:0] fnd(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  assign btn_now  = {i_fStart, i_fStop, i_fSel, i_fInc};
  assign btn_ev   = ~btn_now & btn_prev_q;
  assign start_ev = btn_ev[3];
  assign stop_ev  = btn_ev[2];
  assign sel_ev   = btn_ev[1];
  assign inc_ev   = btn_ev[0];
  assign tick     = (presc_q == PRESC_LAST);
  assign term     = tick && (cnt_q == 12'h001);

  // Next-state logic for the FSM and all datapath registers.
  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    presc_d  = presc_q;
    alarm_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        presc_d = {PW{1'b0}};
        if (sel_ev) sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
        else        sel_d = sel_q;
        if (inc_ev) begin
          case (sel_q)
            2'd0:    preset_d[3:0]  = bcd_inc(preset_q[3:0]);
            2'd1:    preset_d[7:4]  = bcd_inc(preset_q[7:4]);
            2'd2:    preset_d[11:8] = bcd_inc(preset_q[11:8]);
            default: preset_d       = preset_q;
          endcase
        end else begin
          preset_d = preset_q;
        end
        if (start_ev && !stop_ev && (preset_q != 12'h000)) begin
          cnt_d   = preset_q;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        presc_d = tick ? {PW{1'b0}} : presc_q + PW'(1);
        if (term) begin
`ifdef TIMER_RELOAD_EN
          cnt_d   = preset_q;
          alarm_d = 1'b1;
`else
          cnt_d   = 12'h000;
          state_d = ST_DONE;
`endif
        end else if (tick) begin
          cnt_d = bcd_dec(cnt_q);
        end else begin
          cnt_d = cnt_q;
        end
        // A terminal tick without reload wins over a pause request.
        if (stop_ev) begin
          state_d = ST_IDLE;
          presc_d = {PW{1'b0}};
        end else if (start_ev && (state_d != ST_DONE)) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = state_d;
        end
      end
      ST_PAUSE: begin
        if (stop_ev) begin
          state_d = ST_IDLE;
          presc_d = {PW{1'b0}};
        end else if (start_ev) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_DONE: begin
        cnt_d = 12'h000;
        if (start_ev || stop_ev) state_d = ST_IDLE;
        else                     state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifndef TIMER_RELOAD_EN
    alarm_d = (state_d == ST_DONE);
`endif
  end

  // State and datapath registers.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q    <= ST_IDLE;
      preset_q   <= 12'h000;
      cnt_q      <= 12'h000;
      sel_q      <= 2'd0;
      presc_q    <= {PW{1'b0}};
      alarm_q    <= 1'b0;
      btn_prev_q <= 4'b1111;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      presc_q    <= presc_d;
      alarm_q    <= alarm_d;
      btn_prev_q <= btn_now;
    end
  end

  assign disp    = (state_q == ST_IDLE) ? preset_q : cnt_q;
  assign o_Sec0  = fnd(disp[3:0]);
  assign o_Sec1  = fnd(disp[7:4]);
  assign o_Sec2  = fnd(disp[11:8]);
  assign o_Sel   = sel_q;
  assign o_Alarm = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with a prescaler of 4 clocks per tick.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_n = 1'b1, stop_n = 1'b1, sel_n = 1'b1, inc_n = 1'b1;
  logic [6:0] sec0, sec1, sec2;
  logic [1:0] sel;
  logic       alarm;
  int         n_checks = 0;
  int         n_errors = 0;

  countdown_timer #(.LST_CLK(3)) dut (
    .i_Clk(clk), .i_Rst(rst_n), .i_fStart(start_n), .i_fStop(stop_n),
    .i_fSel(sel_n), .i_fInc(inc_n), .o_Sec0(sec0), .o_Sec1(sec1),
    .o_Sec2(sec2), .o_Sel(sel), .o_Alarm(alarm)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [31:0] dexp(input int d2, input int d1, input int d0);
    return {11'd0, seg(d2), seg(d1), seg(d0)};
  endfunction

  function automatic logic [31:0] dgot();
    return {11'd0, sec2, sec1, sec0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the event acts on the next posedge, returns at the following negedge.
  task automatic press(input int b);
    case (b)
      0: start_n = 1'b0;
      1: stop_n  = 1'b0;
      2: sel_n   = 1'b0;
      default: inc_n = 1'b0;
    endcase
    @(negedge clk);
    start_n = 1'b1; stop_n = 1'b1; sel_n = 1'b1; inc_n = 1'b1;
  endtask

  task automatic press_n(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      press(b);
      @(negedge clk);
    end
  endtask

  task automatic set_preset(input int d2, input int d1, input int d0);
    press_n(3, d0); press_n(2, 1);
    press_n(3, d1); press_n(2, 1);
    press_n(3, d2); press_n(2, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    ticks(2);
    chk("rst_disp", dgot(), dexp(0, 0, 0));
    chk("rst_sel", {30'd0, sel}, 32'd1 - 32'd1);
    chk("rst_alarm", {31'd0, alarm}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of a run at count 047
    set_preset(0, 4, 7);
    press_n(2, 1);
    press(0);
    chk("run047", dgot(), dexp(0, 4, 7));
    chk("run_sel1", {30'd0, sel}, 32'd1);
    ticks(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_disp", dgot(), dexp(0, 0, 0));
    chk("arst_sel", {30'd0, sel}, 32'd0);
    chk("arst_alarm", {31'd0, alarm}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(1);
    chk("rel_disp", dgot(), dexp(0, 0, 0));

    // Preset editing and preset immunity while running
    do_reset();
    press_n(2, 2); press_n(3, 3); press_n(2, 2); press_n(3, 1);
    chk("edit_sel", {30'd0, sel}, 32'd1);
    chk("edit_preset", dgot(), dexp(3, 1, 0));
    press(0);
    ticks(1);
    press_n(3, 2);
    press(1);
    chk("run_inc_preset", dgot(), dexp(3, 1, 0));
    chk("run_inc_sel", {30'd0, sel}, 32'd1);

`ifndef TIMER_RELOAD_EN
    // Preset 002 runs down to DONE
    do_reset();
    set_preset(0, 0, 2);
    press(0);
    chk("c002", dgot(), dexp(0, 0, 2));
    ticks(3);
    chk("c002_hold", dgot(), dexp(0, 0, 2));
    ticks(1);
    chk("c001", dgot(), dexp(0, 0, 1));
    ticks(3);
    chk("c001_alarm", {31'd0, alarm}, 32'd0);
    ticks(1);
    chk("c000", dgot(), dexp(0, 0, 0));
    chk("done_alarm", {31'd0, alarm}, 32'd1);
    ticks(3);
    chk("done_hold", dgot(), dexp(0, 0, 0));
    chk("done_alarm_hold", {31'd0, alarm}, 32'd1);
    press(1);
    chk("stop_idle", dgot(), dexp(0, 0, 2));
    chk("stop_alarm", {31'd0, alarm}, 32'd0);
`else
    // Reload mode: count cycles 002,001,002 with a one-cycle alarm pulse
    do_reset();
    set_preset(0, 0, 2);
    press(0);
    ticks(4);
    chk("rl_c001", dgot(), dexp(0, 0, 1));
    chk("rl_a0", {31'd0, alarm}, 32'd0);
    ticks(4);
    chk("rl_c002", dgot(), dexp(0, 0, 2));
    chk("rl_pulse1", {31'd0, alarm}, 32'd1);
    ticks(1);
    chk("rl_pulse_end", {31'd0, alarm}, 32'd0);
    ticks(3);
    chk("rl_c001b", dgot(), dexp(0, 0, 1));
    ticks(4);
    chk("rl_pulse2", {31'd0, alarm}, 32'd1);
    chk("rl_c002b", dgot(), dexp(0, 0, 2));
`endif

    // Pause and resume keep the held prescaler phase
    do_reset();
    set_preset(0, 1, 0);
    press(0);
    ticks(1);
    press(0);
    ticks(20);
    chk("pause_hold", dgot(), dexp(0, 1, 0));
    press(0);
    chk("resume0", dgot(), dexp(0, 1, 0));
    ticks(1);
    chk("resume1", dgot(), dexp(0, 1, 0));
    ticks(1);
    chk("resume_dec", dgot(), dexp(0, 0, 9));

    // Start and Stop on the same edge while running
    do_reset();
    set_preset(0, 0, 5);
    press(0);
    ticks(5);
    chk("c004", dgot(), dexp(0, 0, 4));
    start_n = 1'b0; stop_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1; stop_n = 1'b1;
    chk("both_idle", dgot(), dexp(0, 0, 5));
    chk("both_alarm", {31'd0, alarm}, 32'd0);

    // Start with a zero preset stays in IDLE, so Inc still edits
    do_reset();
    press_n(0, 1);
    ticks(4);
    chk("zero_start", dgot(), dexp(0, 0, 0));
    press(3);
    chk("zero_idle_inc", dgot(), dexp(0, 0, 1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
